// File: rtl/loba_mul_pipe.sv
// loba_mul_pipe: pipelined leading-one-bit approximate (LOBA) multiplier.
//
// Each operand is reduced to at most two K-bit windows. The high window
// starts at the leading one, and the low window starts at the leading one
// of the remainder. The product is the sum of 1..4 window cross-products,
// selected per beat by in_mode (0 = LOBA0 .. 3 = LOBA3). Operands are
// signed or unsigned per beat, selected by in_signed.
//
// Pipeline: S1 sign/abs -> S2 window split -> S3 partial-product sum/sign.
// An accepted beat reaches out_valid 3 cycles later when nothing stalls.
//
// Optional build macro LOBA_EXACT_FLAG_EN adds the out_exact output. It is
// high when both magnitudes fit in a single K-bit window, which makes
// out_r the true product in every mode.
//
// Handshake: a beat moves on a rising edge where valid && ready are both
// high. A stage loads when it is empty or its contents leave in the same
// edge. in_ready is the S1 load enable. out_valid and out_r are held
// stable until out_ready accepts them.
module loba_mul_pipe #(
  parameter int K  = 4,
  parameter int NA = 16,
  parameter int NB = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NA-1:0]    in_a,
  input  logic [NB-1:0]    in_b,
  input  logic [1:0]       in_mode,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOBA_EXACT_FLAG_EN
  output logic             out_exact,
`endif
  output logic [NA+NB-1:0] out_r
);

  localparam int RW = NA + NB;
  localparam int NM = (NA > NB) ? NA : NB;
  localparam int KW = $clog2(NM);

  // One operand after the split: high/low windows and their MSB positions
  typedef struct packed {
    logic [K-1:0]  h;
    logic [K-1:0]  l;
    logic [KW-1:0] kh;
    logic [KW-1:0] kl;
  } split_t;

  // Window split of one magnitude. A zero operand yields h = l = 0 and
  // kh = kl = K-1.
  function automatic split_t split_op(input logic [NM-1:0] x);
    split_t s;
    logic [NM-1:0] lo;
    logic [NM-1:0] mask;
    int p;
    int q;
    int kh;
    int kl;
    p = 0;
    for (int i = 0; i < NM; i++) begin
      if (x[i]) p = i;
    end
    kh = (p > K - 1) ? p : K - 1;
    // The remainder is every bit below the high window (empty when kh == K-1)
    mask = (NM'(1) << (kh - K + 1)) - NM'(1);
    lo = x & mask;
    q = 0;
    for (int i = 0; i < NM; i++) begin
      if (lo[i]) q = i;
    end
    kl = (q > K - 1) ? q : K - 1;
    s.h  = K'(x >> (kh - K + 1));
    s.l  = K'(lo >> (kl - K + 1));
    s.kh = KW'(kh);
    s.kl = KW'(kl);
    return s;
  endfunction

  // Stage registers
  logic          s1_v_q, s2_v_q, out_v_q;
  logic [NA-1:0] s1_a_q, s1_a_d;
  logic [NB-1:0] s1_b_q, s1_b_d;
  logic          s1_sign_q, s1_sign_d;
  logic [1:0]    s1_mode_q;

  logic [K-1:0]  s2_ah_q, s2_al_q, s2_bh_q, s2_bl_q;
  logic [KW-1:0] s2_kha_q, s2_kla_q, s2_khb_q, s2_klb_q;
  logic          s2_sign_q;
  logic [1:0]    s2_mode_q;
  split_t        sa_d, sb_d;

  logic [RW-1:0] out_r_q, out_r_d;

  // Stage load enables; each stage loads when empty or draining
  logic s1_en, s2_en, s3_en;

  // Ready chain, from the output back to the input
  always_comb begin
    s3_en    = !out_v_q || out_ready;
    s2_en    = !s2_v_q || s3_en;
    s1_en    = !s1_v_q || s2_en;
    in_ready = s1_en;
  end

  // S1 combinational: magnitudes and result sign
  always_comb begin
    s1_a_d    = in_a;
    s1_b_d    = in_b;
    s1_sign_d = 1'b0;
    if (in_signed) begin
      if (in_a[NA-1]) s1_a_d = -in_a;
      if (in_b[NB-1]) s1_b_d = -in_b;
      s1_sign_d = in_a[NA-1] ^ in_b[NB-1];
    end
  end

  // S2 combinational: window split of both magnitudes
  always_comb begin
    sa_d = split_op(NM'(s1_a_q));
    sb_d = split_op(NM'(s1_b_q));
  end

  // S3 combinational: shifted cross-products, term selection, sign restore
  logic [2*K-1:0] p0, p1, p2, p3;
  logic [RW-1:0]  t0, t1, t2, t3, sum;
  int             sh0, sh1, sh2, sh3;
  always_comb begin
    p0  = s2_ah_q * s2_bh_q;
    p1  = s2_ah_q * s2_bl_q;
    p2  = s2_al_q * s2_bh_q;
    p3  = s2_al_q * s2_bl_q;
    sh0 = int'(s2_kha_q) + int'(s2_khb_q) - 2 * (K - 1);
    sh1 = int'(s2_kha_q) + int'(s2_klb_q) - 2 * (K - 1);
    sh2 = int'(s2_kla_q) + int'(s2_khb_q) - 2 * (K - 1);
    sh3 = int'(s2_kla_q) + int'(s2_klb_q) - 2 * (K - 1);
    t0  = RW'(p0) << sh0;
    t1  = RW'(p1) << sh1;
    t2  = RW'(p2) << sh2;
    t3  = RW'(p3) << sh3;
    sum = t0;
    if (s2_mode_q >= 2'd1) sum = sum + t1;
    if (s2_mode_q >= 2'd2) sum = sum + t2;
    if (s2_mode_q == 2'd3) sum = sum + t3;
    out_r_d = s2_sign_q ? -sum : sum;
  end

  // Stage valid bits; reset flushes every in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      out_v_q <= 1'b0;
    end else begin
      if (s1_en) s1_v_q  <= in_valid;
      if (s2_en) s2_v_q  <= s1_v_q;
      if (s3_en) out_v_q <= s2_v_q;
    end
  end

  // S1 data capture on an accepted input beat
  always_ff @(posedge clk) begin
    if (s1_en && in_valid) begin
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_sign_q <= s1_sign_d;
      s1_mode_q <= in_mode;
    end
  end

  // S2 data capture of the split windows
  always_ff @(posedge clk) begin
    if (s2_en && s1_v_q) begin
      s2_ah_q   <= sa_d.h;
      s2_al_q   <= sa_d.l;
      s2_kha_q  <= sa_d.kh;
      s2_kla_q  <= sa_d.kl;
      s2_bh_q   <= sb_d.h;
      s2_bl_q   <= sb_d.l;
      s2_khb_q  <= sb_d.kh;
      s2_klb_q  <= sb_d.kl;
      s2_sign_q <= s1_sign_q;
      s2_mode_q <= s1_mode_q;
    end
  end

  // Output register; holds while the downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r_q <= '0;
    end else if (s3_en && s2_v_q) begin
      out_r_q <= out_r_d;
    end
  end

  assign out_valid = out_v_q;
  assign out_r     = out_r_q;

`ifdef LOBA_EXACT_FLAG_EN
  // A low window is zero exactly when the remainder below the high window is zero
  logic exact_q, exact_d;
  assign exact_d = (s2_al_q == '0) && (s2_bl_q == '0);

  // Exact flag travels with out_r and is held with it
  always_ff @(posedge clk) begin
    if (rst) begin
      exact_q <= 1'b0;
    end else if (s3_en && s2_v_q) begin
      exact_q <= exact_d;
    end
  end

  assign out_exact = exact_q;
`endif

endmodule

// File: tb/tb_loba_mul_pipe.sv
// tb_loba_mul_pipe: vector table, stall, reset-flush and random-stream
// checks for loba_mul_pipe with K=4, NA=NB=16.
module tb_loba_mul_pipe;
  localparam int K  = 4;
  localparam int NA = 16;
  localparam int NB = 16;
  localparam int RW = NA + NB;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [NA-1:0] in_a;
  logic [NB-1:0] in_b;
  logic [1:0]    in_mode;
  logic [RW-1:0] out_r;
`ifdef LOBA_EXACT_FLAG_EN
  logic          out_exact;
`endif

  loba_mul_pipe #(.K(K), .NA(NA), .NB(NB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef LOBA_EXACT_FLAG_EN
    .out_exact(out_exact),
`endif
    .out_r(out_r)
  );

  // Scoreboard state: {exact, result} per outstanding beat, plus accept cycle
  logic [RW:0] exp_q[$];
  int          acc_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          chk_lat = 1'b0;
  int          n_pop = 0;
  int          n_unexp = 0;
  int          last_pop_cyc = 0;
  bit          saw_stall = 1'b0;
  bit          held = 1'b0;
  logic [RW-1:0] held_r;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the high part of x keeps only the K bits from the leading one
  function automatic longint unsigned hi_part(input longint unsigned x);
    int p;
    if (x < (64'd1 << K)) return x;
    p = 0;
    for (int i = 0; i < 64; i++) if (x[i]) p = i;
    return x & ~((64'd1 << (p - K + 1)) - 64'd1);
  endfunction

  function automatic logic [RW:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] m, input logic s);
    longint unsigned ma, mb, ha, hb, la, lb, sum;
    logic [RW-1:0] r;
    logic ex;
    ma = a;
    mb = b;
    if (s && a[15]) ma = 64'h10000 - a;
    if (s && b[15]) mb = 64'h10000 - b;
    ha = hi_part(ma);
    hb = hi_part(mb);
    la = hi_part(ma - ha);
    lb = hi_part(mb - hb);
    sum = ha * hb;
    if (m >= 2'd1) sum += ha * lb;
    if (m >= 2'd2) sum += la * hb;
    if (m == 2'd3) sum += la * lb;
    r = sum[RW-1:0];
    if (s && (a[15] ^ b[15])) r = -r;
    ex = (ma == ha) && (mb == hb);
    return {ex, r};
  endfunction

  // Output monitor: hold check, pop/compare, latency
  always @(negedge clk) begin
    logic [RW:0] e;
    int a0;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && !out_ready) begin
        if (held) check("hold_out_r", out_r, held_r);
        held = 1'b1;
        held_r = out_r;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          n_unexp++;
          $display("FAIL unexpected_out: got %0h with no beat outstanding", out_r);
        end else begin
          e = exp_q.pop_front();
          a0 = acc_q.pop_front();
          check("result", out_r, e[RW-1:0]);
`ifdef LOBA_EXACT_FLAG_EN
          check("exact", out_exact, e[RW]);
`endif
          if (chk_lat) check("latency", cyc - a0, 3);
          n_pop++;
          last_pop_cyc = cyc;
        end
      end
    end
  end

  // Driver: present a beat (caller is just after a rising edge), push on accept
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                      input logic s, input logic [RW:0] e);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    in_a = a; in_b = b; in_mode = m; in_signed = s; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [15:0]   a;
    logic [15:0]   b;
    logic [1:0]    m;
    logic          s;
    logic [RW-1:0] r;
    logic          ex;
  } vec_t;
  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, rel_cyc, rel_pops;
    bit rnd_done;
    logic [15:0] ra, rb;
    logic [1:0] rm;
    logic rs;

    vecs[0]  = '{16'd200,  16'd100,  2'd0, 1'b0, 32'd18432,    1'b0};
    vecs[1]  = '{16'd200,  16'd100,  2'd1, 1'b0, 32'd19200,    1'b0};
    vecs[2]  = '{16'd200,  16'd100,  2'd2, 1'b0, 32'd19968,    1'b0};
    vecs[3]  = '{16'd200,  16'd100,  2'd3, 1'b0, 32'd20000,    1'b0};
    vecs[4]  = '{16'hFF38, 16'd100,  2'd3, 1'b1, 32'hFFFFB1E0, 1'b0};
    vecs[5]  = '{16'hFF38, 16'hFF9C, 2'd3, 1'b1, 32'd20000,    1'b0};
    vecs[6]  = '{16'd0,    16'd1234, 2'd2, 1'b0, 32'd0,        1'b0};
    vecs[7]  = '{16'hFFFB, 16'd0,    2'd1, 1'b1, 32'd0,        1'b1};
    vecs[8]  = '{16'd5,    16'd3,    2'd0, 1'b0, 32'd15,       1'b1};
    vecs[9]  = '{16'h8000, 16'd1,    2'd0, 1'b1, 32'hFFFF8000, 1'b1};
    vecs[10] = '{16'hFFFF, 16'hFFFF, 2'd3, 1'b0, 32'hFE010000, 1'b0};
    vecs[11] = '{16'hFFFF, 16'hFFFF, 2'd0, 1'b0, 32'hE1000000, 1'b0};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
    in_signed = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_r", out_r, 0);
    check("reset_in_ready", in_ready, 1);

    // Table vectors, one at a time, with latency
    chk_lat = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].s, {vecs[i].ex, vecs[i].r});
      idle();
      wait_drain(20);
    end

    // Back-to-back beats alternating mode 0/3 and signedness
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rm = (i % 2 == 1) ? 2'd3 : 2'd0;
      rs = ((i / 2) % 2 == 1) ^ (i % 2 == 1);
      send(ra, rb, rm, rs, model(ra, rb, rm, rs));
    end
    idle();
    wait_drain(30);

    // Eight-beat stream with out_ready low during cycles 4..9
    chk_lat = 1'b0;
    base = n_pop;
    saw_stall = 1'b0;
    rel_cyc = 0;
    rel_pops = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = 16'(1000 + 37 * i);
          rb = 16'(300 + 11 * i);
          send(ra, rb, 2'(i), 1'b0, model(ra, rb, 2'(i), 1'b0));
        end
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
        rel_cyc = cyc;
        rel_pops = n_pop;
      end
    join
    for (int n = 0; n < 50 && n_pop < base + 8; n++) begin
      @(posedge clk); #1;
    end
    check("stall_in_ready_drop", saw_stall, 1);
    check("stall_count", n_pop - base, 8);
    check("stall_throughput", last_pop_cyc - rel_cyc + 1, base + 8 - rel_pops);
    wait_drain(10);

    // Reset with two beats in flight
    chk_lat = 1'b1;
    send(16'd200, 16'd100, 2'd3, 1'b0, model(16'd200, 16'd100, 2'd3, 1'b0));
    send(16'd77, 16'd91, 2'd1, 1'b0, model(16'd77, 16'd91, 2'd1, 1'b0));
    idle();
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_out_r", out_r, 0);
    repeat (6) @(posedge clk);
    #1;
    check("flush_no_ghost", n_unexp, 0);
    send(16'hFF38, 16'd100, 2'd3, 1'b1, {1'b0, 32'hFFFFB1E0});
    idle();
    wait_drain(20);

    // Random stream with random back-pressure and input gaps
    chk_lat = 1'b0;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          ra = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
          rb = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
          rm = 2'($urandom_range(0, 3));
          rs = 1'($urandom_range(0, 1));
          send(ra, rb, rm, rs, model(ra, rb, rm, rs));
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk); #1;
          end
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/loba_mul_pipe.md
Name: loba_mul_pipe

Overview:
- Pipelined, parametrised LOBA (leading-one-bit approximate) multiplier with valid/ready handshakes. Successor to the combinational LOBA0..3 signed/unsigned multiplier family.
- Two runtime per-transaction controls, both carried with the operands through the pipeline:
  - term count (0..3 extra partial products), selecting LOBA0..LOBA3 accuracy;
  - signed/unsigned operand interpretation.
- Used as the drop-in approximate multiplier for streaming datapaths that need throughput and back-pressure.

Parameters:
- K, 4, window width in bits of each leading-one segment (K >= 2, K <= min(NA, NB)).
- NA, 16, width of operand a.
- NB, 16, width of operand b.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_a  input  NA  operand a.
- in_b  input  NB  operand b.
- in_mode  input  2  number of partial products minus 1 (0=LOBA0 .. 3=LOBA3).
- in_signed  input  1  1: operands are two's complement; 0: unsigned.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- out_r  output  NA+NB  product, two's complement when the beat's in_signed=1.

Behaviour:
- Reset: all stage valid bits cleared; out_valid=0, out_r=0; in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight beats, with no partial output.
- Handshake: a transfer occurs when valid&&ready on the same edge. out_valid/out_r are held stable until accepted.
- Pipeline: 3 register stages, S1 sign/abs, S2 split, S3 sum/sign.
  - Latency is exactly 3 cycles from input transfer to out_valid when unstalled; throughput is 1 beat/cycle.
  - A stage advances when the next stage is empty or advancing. in_ready = !S1.valid || S1 advances. This is full-throughput back-pressure with no combinational path from out_ready to in_valid-dependent logic beyond the ready chain.
- S1 (sign/abs):
  - If in_signed, |a| and |b| are formed with MSB-as-sign two's complement negation; otherwise operands are passed raw.
  - out_sign = in_signed & (a[NA-1] ^ b[NB-1]).
  - Most-negative inputs (e.g. 0x8000) yield an unsigned magnitude 2^(N-1), which is valid.
- S2 (split), per operand X of width N:
  - p = position of the leading one of X. kh = max(p, K-1); Xh = X[kh -: K].
  - L = X[kh-K:0] when kh >= K, else L = 0.
  - q = leading one of L. kl = max(q, K-1); Xl = L[kl -: K], or 0 when L = 0.
  - X = 0 gives Xh = Xl = 0 and kh = kl = K-1.
- S3 (sum/sign):
  - T0 = (Ah*Bh) << (kha+khb-2(K-1)).
  - T1 = (Ah*Bl) << (kha+klb-2(K-1)).
  - T2 = (Al*Bh) << (kla+khb-2(K-1)).
  - T3 = (Al*Bl) << (kla+klb-2(K-1)).
  - Sum = T0 + T1..Tmode (terms above mode excluded). Sum is truncated to NA+NB bits, and cannot overflow for mode <= 3.
  - out_r = out_sign ? -Sum : Sum.
- Mode and signedness are per-beat: back-to-back beats with different in_mode/in_signed are each computed with their own settings.

Optional Feature:
- Macro: LOBA_EXACT_FLAG_EN.
- Defined:
  - Adds output port out_exact (1 bit), aligned with out_r and held with it.
  - out_exact = 1 iff L = 0 for both operands, i.e. both magnitudes fit in one K-bit window. In that case out_r equals the true product for every mode.
  - out_exact resets to 0.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- K=4, NA=NB=16, unsigned, a=200, b=100, modes 0,1,2,3 -> out_r = 18432, 19200, 19968, 20000 respectively, each 3 cycles after acceptance.
- Signed, mode 3, a=-200 (0xFF38), b=100 -> out_r=0xFFFFB1E0 (-20000); a=-200, b=-100 -> 20000.
- a=0 or b=0, any mode/sign -> out_r=0. a=5, b=3 mode 0 -> 15 (out_exact=1 when enabled); a=200, b=100 -> out_exact=0.
- Stream 8 beats with out_ready low for cycles 4-9:
  - in_ready drops once the 3 stages fill;
  - out_r is held stable while stalled;
  - all 8 results arrive in order with no loss or duplication;
  - 1 beat/cycle once out_ready returns high.
- Alternating in_mode 0/3 and in_signed 0/1 on consecutive beats -> each result matches its own settings.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and out_r=0 next cycle; the dropped beats never appear; a new beat after reset returns a correct result at latency 3.
